// File: rtl/attn_inst_seq_if.sv
// attn_inst_seq_if: host/core-side bundle of the attention instruction sequencer.
//   start      host -> seq   one-cycle pulse, begins a pass when idle
//   din_valid  host -> seq   valid mem_in word this cycle
//   din_ready  seq  -> host  Q/K words accepted this cycle
//   inst       seq  -> core  19-bit instruction word
//   busy       seq  -> host  pass in progress
//   done       seq  -> host  one-cycle end-of-pass pulse
//   out_valid  seq  -> host  normalized row present on core output
//   out_row    seq  -> host  index of that row
interface attn_inst_seq_if;
    logic        start;
    logic        din_valid;
    logic        din_ready;
    logic [18:0] inst;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic [3:0]  out_row;

    modport master (
        output start, din_valid,
        input  din_ready, inst, busy, done, out_valid, out_row
    );

    modport slave (
        input  start, din_valid,
        output din_ready, inst, busy, done, out_valid, out_row
    );
endinterface

// File: rtl/attn_inst_seq.sv
// attn_inst_seq: instruction sequencer for one Q*K^T + normalization pass of
// the attention core. A single start pulse walks Q load, K load, kernel
// preload, MAC execute, OFIFO->PSUM drain and SFP accumulate/divide, and
// flags each normalized output row.
// Ports:
//   clk    clock
//   reset  synchronous, active-low
//   bus    attn_inst_seq_if.slave (start/din_valid in; inst, din_ready,
//          busy, done, out_valid, out_row out)
// inst map: [18] div [17] acc [16] ofifo_rd [15:12] qkmem_add [11:8] pmem_add
//           [7] execute [6] load [5] qmem_rd [4] qmem_wr [3] kmem_rd
//           [2] kmem_wr [1] pmem_rd [0] pmem_wr
module attn_inst_seq #(
    parameter int col        = 8,
    parameter int rows       = 16,
    parameter int load_gap   = 8,
    parameter int exec_drain = 16
) (
    input logic             clk,
    input logic             reset,
    attn_inst_seq_if.slave  bus
);
    // Wider than the 4-bit address fields so EXEC/KFEED can count their
    // trailing (n+1)-th cycle and GAP/DRAIN can span any parameter value.
    localparam int CW = 8;

    typedef enum logic [3:0] {
        S_IDLE, S_QLOAD, S_KLOAD, S_KFEED, S_GAP,
        S_EXEC, S_DRAIN, S_OFIFO, S_NORM, S_DONE
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [1:0]     ph, ph_n;      // NORM phase within a row
    logic           kmem_rd, qmem_rd;
    logic           kd, qd;        // kmem_rd / qmem_rd delayed one cycle
    logic [18:0]    inst;
    logic           din_ready, done, out_valid;
    logic [3:0]     out_row;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            ph    <= '0;
            kd    <= 1'b0;
            qd    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ph    <= ph_n;
            kd    <= kmem_rd;
            qd    <= qmem_rd;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ph_n      = ph;
        kmem_rd   = 1'b0;
        qmem_rd   = 1'b0;
        inst      = '0;
        din_ready = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_row   = '0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_n = S_QLOAD;
                    cnt_n   = '0;
                end
            end
            S_QLOAD, S_KLOAD: begin
                din_ready      = 1'b1;
                inst[15:12]    = cnt[3:0];
                if (state == S_QLOAD) inst[4] = bus.din_valid;
                else                  inst[2] = bus.din_valid;
                if (bus.din_valid) begin
                    if (cnt == CW'(rows - 1)) begin
                        state_n = (state == S_QLOAD) ? S_KLOAD : S_KFEED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_KFEED: begin
                if (cnt < CW'(col)) begin
                    kmem_rd     = 1'b1;
                    inst[15:12] = cnt[3:0];
                end
                if (cnt == CW'(col)) begin
                    state_n = S_GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == CW'(load_gap - 1)) begin
                    state_n = S_EXEC;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_EXEC: begin
                if (cnt < CW'(rows)) begin
                    qmem_rd     = 1'b1;
                    inst[15:12] = cnt[3:0];
                end
                if (cnt == CW'(rows)) begin
                    state_n = S_DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == CW'(exec_drain - 1)) begin
                    state_n = S_OFIFO;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_OFIFO: begin
                // Fall-through OFIFO head: read and PSUM write share the cycle.
                inst[16]   = 1'b1;
                inst[0]    = 1'b1;
                inst[11:8] = cnt[3:0];
                if (cnt == CW'(rows - 1)) begin
                    state_n = S_NORM;
                    cnt_n   = '0;
                    ph_n    = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_NORM: begin
                case (ph)
                    2'd0: begin
                        inst[1]    = 1'b1;
                        inst[11:8] = cnt[3:0];
                        // Previous row's divide result is on the core output now.
                        if (cnt != '0) begin
                            out_valid = 1'b1;
                            out_row   = 4'(cnt - CW'(1));
                        end
                        ph_n = 2'd1;
                    end
                    2'd1: begin
                        inst[17] = 1'b1;
                        ph_n     = 2'd2;
                    end
                    2'd2: begin
                        inst[18] = 1'b1;
                        ph_n     = 2'd0;
                        if (cnt == CW'(rows - 1)) begin
                            state_n = S_DONE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    default: ph_n = 2'd0;
                endcase
            end
            S_DONE: begin
                done      = 1'b1;
                out_valid = 1'b1;
                out_row   = 4'(rows - 1);
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        inst[5] = qmem_rd;
        inst[3] = kmem_rd;
        inst[6] = kd;
        inst[7] = qd;
    end

    assign bus.inst      = inst;
    assign bus.din_ready = din_ready;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done;
    assign bus.out_valid = out_valid;
    assign bus.out_row   = out_row;
endmodule
